hub75_scan_driver: RTL

HUB75_SCAN_DRIVER -- requirements
Module: hub75_scan_driver

---
 rtl/hub75_scan_driver.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hub75_scan_driver.sv
// HUB75 LED panel scan driver: shifts one row pair, latches it, then shows it for ON_TICKS ticks.
// Optional macro HUB75_BRIGHTNESS_EN adds an 8-bit brightness input that shortens the OE window.
module hub75_scan_driver #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 5,
  parameter int CLK_DIV  = 27,
  parameter int ON_TICKS = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  output logic [ROW_BITS-1:0]       pix_row,
  output logic [$clog2(COLS)-1:0]   pix_col,
  input  logic [2:0]                pix_rgb_top,
  input  logic [2:0]                pix_rgb_bot,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]                brightness,
`endif
  output logic                      H75_R1,
  output logic                      H75_G1,
  output logic                      H75_B1,
  output logic                      H75_R2,
  output logic                      H75_G2,
  output logic                      H75_B2,
  output logic                      H75_Clk,
  output logic                      H75_Lat,
  output logic                      H75_OE,
  output logic                      H75_A,
  output logic                      H75_B,
  output logic                      H75_C,
  output logic                      H75_D,
  output logic                      H75_E,
  output logic                      frame_start
);

  localparam int CW  = $clog2(COLS);
  localparam int DW  = $clog2(CLK_DIV);
  localparam int OW  = $clog2(ON_TICKS + 1);
  localparam int RB5 = (ROW_BITS < 5) ? ROW_BITS : 5;

  localparam logic [DW-1:0]       DivLast = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]       DivOne  = DW'(1);
  localparam logic [CW-1:0]       ColLast = CW'(COLS - 1);
  localparam logic [CW-1:0]       ColOne  = CW'(1);
  localparam logic [OW-1:0]       OnLast  = OW'(ON_TICKS - 1);
  localparam logic [OW-1:0]       OnOne   = OW'(1);
  localparam logic [ROW_BITS-1:0] RowOne  = ROW_BITS'(1);

  typedef enum logic [2:0] {
    StIdle, StShiftLo, StShiftHi, StBlank, StLatch, StUnlatch, StDisplay
  } state_e;

  state_e              r_state;
  logic [DW-1:0]       r_div;
  logic [CW-1:0]       r_col;
  logic [ROW_BITS-1:0] r_row;
  logic [OW-1:0]       r_on;
  logic                r_started;
  logic                w_tick;
  logic [ROW_BITS-1:0] w_row_next;
  logic [CW-1:0]       w_col_next;
  logic [OW-1:0]       w_on_next;
  logic [4:0]          w_row_ext;

  assign w_tick     = (r_div == DivLast);
  assign w_row_next = r_row + RowOne;
  assign w_col_next = r_col + ColOne;
  assign w_on_next  = r_on + OnOne;

  // Address lines beyond ROW_BITS stay low.
  always_comb begin
    w_row_ext = '0;
    for (int i = 0; i < RB5; i++) w_row_ext[i] = r_row[i];
  end

`ifdef HUB75_BRIGHTNESS_EN
  logic [OW-1:0] r_bright;
  logic [OW-1:0] w_bmin;
  assign w_bmin = (32'(brightness) < ON_TICKS) ? OW'(brightness) : OW'(ON_TICKS);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DivOne;
    end
  end

  // The pixel address always leads the panel by one shift slot, so the
  // memory has a full tick to settle before the SHIFT_LO sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_col       <= '0;
      r_row       <= '0;
      r_on        <= '0;
      r_started   <= 1'b0;
      pix_row     <= '0;
      pix_col     <= '0;
      H75_R1      <= 1'b0;
      H75_G1      <= 1'b0;
      H75_B1      <= 1'b0;
      H75_R2      <= 1'b0;
      H75_G2      <= 1'b0;
      H75_B2      <= 1'b0;
      H75_Clk     <= 1'b0;
      H75_Lat     <= 1'b0;
      H75_OE      <= 1'b1;
      {H75_E, H75_D, H75_C, H75_B, H75_A} <= '0;
      frame_start <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
      r_bright    <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          StIdle: begin
            if (enable) begin
              r_state   <= StShiftLo;
              r_started <= 1'b1;
              if (!r_started) frame_start <= 1'b1;
              H75_Clk   <= 1'b0;
              {H75_B1, H75_G1, H75_R1} <= pix_rgb_top;
              {H75_B2, H75_G2, H75_R2} <= pix_rgb_bot;
            end
          end
          StShiftLo: begin
            r_state <= StShiftHi;
            H75_Clk <= 1'b1;
            pix_col <= (r_col == ColLast) ? '0 : w_col_next;
          end
          StShiftHi: begin
            H75_Clk <= 1'b0;
            if (r_col != ColLast) begin
              r_state <= StShiftLo;
              r_col   <= w_col_next;
              {H75_B1, H75_G1, H75_R1} <= pix_rgb_top;
              {H75_B2, H75_G2, H75_R2} <= pix_rgb_bot;
            end else begin
              r_state <= StBlank;
              H75_OE  <= 1'b1;
            end
          end
          StBlank: begin
            r_state <= StLatch;
            H75_Lat <= 1'b1;
          end
          StLatch: begin
            r_state <= StUnlatch;
            H75_Lat <= 1'b0;
            {H75_E, H75_D, H75_C, H75_B, H75_A} <= w_row_ext;
          end
          StUnlatch: begin
            r_state <= StDisplay;
            r_on    <= '0;
            pix_row <= w_row_next;
`ifdef HUB75_BRIGHTNESS_EN
            r_bright <= w_bmin;
            H75_OE   <= (w_bmin == '0);
`else
            H75_OE   <= 1'b0;
`endif
          end
          StDisplay: begin
            if (r_on == OnLast) begin
              H75_OE <= 1'b1;
              r_row  <= w_row_next;
              r_col  <= '0;
              if (w_row_next == '0) frame_start <= 1'b1;
              if (enable) begin
                r_state <= StShiftLo;
                H75_Clk <= 1'b0;
                {H75_B1, H75_G1, H75_R1} <= pix_rgb_top;
                {H75_B2, H75_G2, H75_R2} <= pix_rgb_bot;
              end else begin
                r_state <= StIdle;
              end
            end else begin
              r_on <= w_on_next;
`ifdef HUB75_BRIGHTNESS_EN
              H75_OE <= !(w_on_next < r_bright);
`endif
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule
